// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to instruction memory over a
// req/ack handshake of variable latency, and holds the IF/ID pipeline register.
// A one-entry skid buffer catches a response that arrives while decode is stalled.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no request outstanding; issues when the skid buffer is empty
// S_WAIT | request outstanding, response will be used
// S_KILL | request outstanding but redirected away; response is discarded
// S_HALT | SYSTEM instruction fetched; no requests until redirect or reset
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [4:0]  ifid_opcode,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic        halted
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL, S_HALT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_imem_addr;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc_plus4;
   logic        r_buf_valid;
   logic [31:0] r_buf_instr;
   logic [31:0] r_buf_pc;

   logic        w_ack;
   logic        w_slot_free;
   logic        w_is_sys;
   logic        w_issue;
   logic        w_accept;
   logic        w_load_resp;
   logic        w_buf_wr;
   logic        w_drain;
   logic [31:0] w_redirect_tgt;

   assign imem_req       = (r_state == S_WAIT) || (r_state == S_KILL);
   assign imem_addr      = r_imem_addr;
   assign halted         = (r_state == S_HALT);
   assign ifid_valid     = r_ifid_valid;
   assign ifid_instr     = r_ifid_instr;
   assign ifid_opcode    = r_ifid_instr[6:2];
   assign ifid_pc        = r_ifid_pc;
   assign ifid_pc_plus4  = r_ifid_pc_plus4;

   // a stray ack with no request outstanding is ignored
   assign w_ack          = imem_ack && imem_req;
   assign w_slot_free    = !r_ifid_valid || !id_stall;
   assign w_is_sys       = (imem_rdata[6:0] == 7'b1110011);
   assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // response routing: straight into IF/ID if decode can take it, else skid buffer
   assign w_load_resp    = w_accept && w_slot_free;
   assign w_buf_wr       = w_accept && !w_slot_free;
   assign w_drain        = !redirect_valid && r_buf_valid && w_slot_free && !w_ack;

   // next-state, issue and accept decisions; redirect dominates normal flow
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      if (redirect_valid) begin
         case (r_state)
            S_WAIT:  w_state_nxt = w_ack ? S_IDLE : S_KILL;
            S_KILL:  w_state_nxt = w_ack ? S_IDLE : S_KILL;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_buf_valid) begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_ack) begin
                  w_accept = 1'b1;
                  if (w_is_sys) begin
                     w_state_nxt = S_HALT;
                  end else if (w_slot_free) begin
                     w_issue = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            S_KILL: begin
               if (w_ack) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // fetch PC, request address, IF/ID register and skid buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc      <= RESET_PC;
         r_imem_addr     <= 32'h0000_0000;
         r_ifid_valid    <= 1'b0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_pc       <= 32'h0000_0000;
         r_ifid_pc_plus4 <= 32'h0000_0004;
         r_buf_valid     <= 1'b0;
         r_buf_instr     <= NOP_INSTR;
         r_buf_pc        <= 32'h0000_0000;
      end else if (redirect_valid) begin
         r_fetch_pc   <= w_redirect_tgt;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
         r_buf_valid  <= 1'b0;
      end else begin
         if (w_issue) begin
            r_imem_addr <= r_fetch_pc;
            r_fetch_pc  <= r_fetch_pc + 32'd4;
         end
         if (w_load_resp) begin
            r_ifid_valid    <= 1'b1;
            r_ifid_instr    <= imem_rdata;
            r_ifid_pc       <= r_imem_addr;
            r_ifid_pc_plus4 <= r_imem_addr + 32'd4;
         end else if (w_drain) begin
            r_ifid_valid    <= 1'b1;
            r_ifid_instr    <= r_buf_instr;
            r_ifid_pc       <= r_buf_pc;
            r_ifid_pc_plus4 <= r_buf_pc + 32'd4;
            r_buf_valid     <= 1'b0;
         end else if (r_ifid_valid && !id_stall) begin
            r_ifid_valid <= 1'b0;
         end
         if (w_buf_wr) begin
            r_buf_valid <= 1'b1;
            r_buf_instr <= imem_rdata;
            r_buf_pc    <= r_imem_addr;
         end
      end
   end

   // memory must only acknowledge an outstanding request
   ack_only_with_req: assert property (@(posedge clk) disable iff (rst) !(imem_ack && !imem_req));

endmodule
